// File: rtl/svga_timing_pkg.sv
// Shared constants for the SVGA 800x600@72 raster timing generator.
// Holds default porch/sync timing, coordinate widths and a window-decode helper.
package svga_timing_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BACK    = 64;

  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BACK    = 23;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Sync windows are half-open: [start, end)
  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  function automatic logic in_window(input int value, input int lo, input int hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/svga_timing_if.sv
// Raster timing bundle: sync pulses, active-video flag and pixel coordinates.
// frame_end marks the last pixel of the frame for downstream frame-rate logic.
interface svga_timing_if;
  import svga_timing_pkg::*;

  logic           hsync;
  logic           vsync;
  logic           video_enable;
  logic           frame_end;
  logic [X_W-1:0] pixel_x;
  logic [Y_W-1:0] pixel_y;

  modport master (
    output hsync,
    output vsync,
    output video_enable,
    output frame_end,
    output pixel_x,
    output pixel_y
  );

  modport slave (
    input hsync,
    input vsync,
    input video_enable,
    input frame_end,
    input pixel_x,
    input pixel_y
  );

endinterface

// File: rtl/mod_counter.sv
// Wrap-around counter 0..MODULUS-1 with synchronous reset and count enable.
// count_next exposes the value to be loaded so callers can register decodes with zero latency.
module mod_counter #(
  parameter int WIDTH   = 11,
  parameter int MODULUS = 1040
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  always_comb begin
    terminal   = (count == LAST);
    count_next = count;
    if (enable) begin
      count_next = terminal ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/svga_timing_gen.sv
// Free-running raster timing generator, one clock per pixel.
// Flags are decoded from the counters' next values so they line up with pixel_x/pixel_y.
module svga_timing_gen
  import svga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  svga_timing_if.master    vid
);

  // H_TOTAL must stay <= 2048 and V_TOTAL <= 1024 to fit the coordinate widths
  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START   = H_VISIBLE + H_FRONT;
  localparam int HS_END     = HS_START + H_SYNC;
  localparam int VS_START   = V_VISIBLE + V_FRONT;
  localparam int VS_END     = VS_START + V_SYNC;

  logic [X_W-1:0] x_count;
  logic [X_W-1:0] x_next;
  logic           x_last;
  logic [Y_W-1:0] y_count;
  logic [Y_W-1:0] y_next;
  logic           y_last;

  logic video_next;
  logic hsync_next;
  logic vsync_next;
  logic video_q;
  logic hsync_q;
  logic vsync_q;

  mod_counter #(
    .WIDTH   (X_W),
    .MODULUS (H_TOTAL)
  ) u_x_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (1'b1),
    .count      (x_count),
    .count_next (x_next),
    .terminal   (x_last)
  );

  mod_counter #(
    .WIDTH   (Y_W),
    .MODULUS (V_TOTAL)
  ) u_y_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (x_last),
    .count      (y_count),
    .count_next (y_next),
    .terminal   (y_last)
  );

  always_comb begin
    video_next = in_window(int'(x_next), 0, H_VISIBLE) && in_window(int'(y_next), 0, V_VISIBLE);
    hsync_next = in_window(int'(x_next), HS_START, HS_END) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next = in_window(int'(y_next), VS_START, VS_END) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Reset values are the decode of (0,0): visible, both syncs idle
  always_ff @(posedge clock) begin
    if (reset) begin
      video_q <= 1'b1;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else begin
      video_q <= video_next;
      hsync_q <= hsync_next;
      vsync_q <= vsync_next;
    end
  end

  assign vid.hsync        = hsync_q;
  assign vid.vsync        = vsync_q;
  assign vid.video_enable = video_q;
  assign vid.pixel_x      = x_count;
  assign vid.pixel_y      = y_count;
  assign vid.frame_end    = x_last && y_last;

endmodule

// File: tb/tb_svga_timing_gen.sv
// Directed bench: default 800x600 timing, a 640x480 active-low override and a tiny
// 15x8 raster that makes whole-frame wrap and vsync period reachable in few cycles.
module tb_svga_timing_gen;

  logic clock = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  svga_timing_if if_a ();
  svga_timing_if if_b ();
  svga_timing_if if_c ();

  svga_timing_gen u_dut (
    .clock (clock),
    .reset (rst_a),
    .vid   (if_a)
  );

  svga_timing_gen #(
    .H_VISIBLE (640), .H_FRONT (16), .H_SYNC (96), .H_BACK (48),
    .V_VISIBLE (480), .V_FRONT (10), .V_SYNC (2),  .V_BACK (33),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) u_vga (
    .clock (clock),
    .reset (rst_b),
    .vid   (if_b)
  );

  svga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) u_small (
    .clock (clock),
    .reset (rst_c),
    .vid   (if_c)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves every instance showing (0,0), one edge before counting resumes
  task automatic pulse_resets(input int n);
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (n) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] act;
    logic [24:0] exp;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    exp = {11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick();
      act = {if_a.pixel_x, if_a.pixel_y, if_a.video_enable, if_a.hsync, if_a.vsync, if_a.frame_end};
      total++;
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL reset_held cyc=%0d got=%h want=%h", i, act, exp);
      end
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    act = {if_a.pixel_x, if_a.pixel_y, if_a.video_enable, if_a.hsync, if_a.vsync, if_a.frame_end};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL reset_release got=%h want=%h", act, exp);
    end
    total++;
    if ({if_b.video_enable, if_b.hsync, if_b.vsync} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL reset_low_pol got=%b want=111", {if_b.video_enable, if_b.hsync, if_b.vsync});
    end
    total++;
    if ({if_c.pixel_x, if_c.pixel_y} !== 21'd0) begin
      bad++;
      $display("[TB] FAIL reset_small got=%h want=0", {if_c.pixel_x, if_c.pixel_y});
    end
    tick();
    total++;
    if ({if_a.pixel_x, if_a.pixel_y} !== {11'd1, 10'd0}) begin
      bad++;
      $display("[TB] FAIL first_count got=(%0d,%0d) want=(1,0)", if_a.pixel_x, if_a.pixel_y);
    end
  endtask

  task automatic test_line();
    logic [24:0] act;
    logic [24:0] exp;
    int hs_count;
    hs_count = 0;
    pulse_resets(1);
    for (int k = 0; k < 1040; k++) begin
      exp = {11'(k), 10'd0, 1'(k < 800), 1'(k >= 856 && k < 976), 1'b0, 1'b0};
      act = {if_a.pixel_x, if_a.pixel_y, if_a.video_enable, if_a.hsync, if_a.vsync, if_a.frame_end};
      total++;
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL line0 k=%0d got=%h want=%h", k, act, exp);
      end
      if (if_a.hsync === 1'b1) hs_count++;
      tick();
    end
    total++;
    if (hs_count != 120) begin
      bad++;
      $display("[TB] FAIL hsync_width got=%0d want=120", hs_count);
    end
    total++;
    if ({if_a.pixel_x, if_a.pixel_y, if_a.video_enable} !== {11'd0, 10'd1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL line_wrap got=(%0d,%0d,%b) want=(0,1,1)",
               if_a.pixel_x, if_a.pixel_y, if_a.video_enable);
    end
  endtask

  task automatic test_reset_mid();
    pulse_resets(1);
    repeat (1540) tick();
    total++;
    if ({if_a.pixel_x, if_a.pixel_y} !== {11'd500, 10'd1}) begin
      bad++;
      $display("[TB] FAIL mid_pre got=(%0d,%0d) want=(500,1)", if_a.pixel_x, if_a.pixel_y);
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    total++;
    if ({if_a.pixel_x, if_a.pixel_y, if_a.video_enable, if_a.hsync, if_a.vsync} !==
        {11'd0, 10'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL mid_reset got=(%0d,%0d,%b%b%b) want=(0,0,100)",
               if_a.pixel_x, if_a.pixel_y, if_a.video_enable, if_a.hsync, if_a.vsync);
    end
    tick();
    total++;
    if (if_a.pixel_x !== 11'd1) begin
      bad++;
      $display("[TB] FAIL mid_resume got=%0d want=1", if_a.pixel_x);
    end
    repeat (854) tick();
    total++;
    if ({if_a.pixel_x, if_a.hsync} !== {11'd855, 1'b0}) begin
      bad++;
      $display("[TB] FAIL mid_pre_hs got=(%0d,%b) want=(855,0)", if_a.pixel_x, if_a.hsync);
    end
    tick();
    total++;
    if ({if_a.pixel_x, if_a.hsync} !== {11'd856, 1'b1}) begin
      bad++;
      $display("[TB] FAIL mid_hs got=(%0d,%b) want=(856,1)", if_a.pixel_x, if_a.hsync);
    end
  endtask

  task automatic test_vga_override();
    logic [24:0] act;
    logic [24:0] exp;
    int low_count;
    low_count = 0;
    pulse_resets(1);
    for (int k = 0; k < 800; k++) begin
      exp = {11'(k), 10'd0, 1'(k < 640), 1'(!(k >= 656 && k < 752)), 1'b1, 1'b0};
      act = {if_b.pixel_x, if_b.pixel_y, if_b.video_enable, if_b.hsync, if_b.vsync, if_b.frame_end};
      total++;
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL vga_line k=%0d got=%h want=%h", k, act, exp);
      end
      if (if_b.hsync === 1'b0) low_count++;
      tick();
    end
    total++;
    if (low_count != 96) begin
      bad++;
      $display("[TB] FAIL vga_hsync_low got=%0d want=96", low_count);
    end
    total++;
    if ({if_b.pixel_x, if_b.pixel_y} !== {11'd0, 10'd1}) begin
      bad++;
      $display("[TB] FAIL vga_wrap got=(%0d,%0d) want=(0,1)", if_b.pixel_x, if_b.pixel_y);
    end
  endtask

  task automatic test_small_frame();
    logic [24:0] act;
    logic [24:0] exp;
    int ex;
    int ey;
    int rises[$];
    int origins[$];
    int vs_high;
    logic prev_vs;
    vs_high = 0;
    pulse_resets(1);
    prev_vs = if_c.vsync;
    for (int k = 0; k < 240; k++) begin
      ex  = k % 15;
      ey  = (k / 15) % 8;
      exp = {11'(ex), 10'(ey), 1'(ex < 8 && ey < 4), 1'(ex >= 10 && ex < 13),
             1'(ey >= 5 && ey < 7), 1'(ex == 14 && ey == 7)};
      act = {if_c.pixel_x, if_c.pixel_y, if_c.video_enable, if_c.hsync, if_c.vsync, if_c.frame_end};
      total++;
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL small k=%0d got=%h want=%h", k, act, exp);
      end
      if (if_c.vsync === 1'b1) vs_high++;
      if (if_c.vsync === 1'b1 && prev_vs === 1'b0) rises.push_back(k);
      if (if_c.pixel_x === 11'd0 && if_c.pixel_y === 10'd0) origins.push_back(k);
      prev_vs = if_c.vsync;
      tick();
    end
    total++;
    if (rises.size() != 2) begin
      bad++;
      $display("[TB] FAIL small_vs_rises got=%0d want=2", rises.size());
    end else begin
      total++;
      if (rises[0] != 75 || rises[1] - rises[0] != 120) begin
        bad++;
        $display("[TB] FAIL small_vs_period got=%0d,%0d want=75,195", rises[0], rises[1]);
      end
    end
    total++;
    if (origins.size() != 2 || origins[1] - origins[0] != 120) begin
      bad++;
      $display("[TB] FAIL small_frame_period got=%0d origins want=2 spaced 120", origins.size());
    end
    total++;
    if (vs_high != 60) begin
      bad++;
      $display("[TB] FAIL small_vs_width got=%0d want=60", vs_high);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_reset_mid();
    test_vga_override();
    test_small_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svga_timing_gen.md
Name: svga_timing_gen

Overview:
- Free-running SVGA 800x600@72 Hz raster timing generator. Runs directly on the 50 MHz board clock; one clock equals one pixel.
- Produces hsync, vsync, an active-video flag and the current pixel coordinates.
- Sits at the front of the video path. The pixel-painting logic and sprite memory use pixel_x, pixel_y and video_enable to choose the colour. Top level drives hsync and vsync straight to the VGA connector.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 56, horizontal front porch (clocks)
- H_SYNC, 120, hsync pulse width (clocks)
- H_BACK, 64, horizontal back porch (clocks)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- HSYNC_POL, 1, asserted level of hsync (1 = active-high)
- VSYNC_POL, 1, asserted level of vsync (1 = active-high)

Ports:
- clock  in  1  pixel/system clock, 50 MHz, rising-edge
- reset  in  1  synchronous, active-high
- hsync  out  1  horizontal sync, level given by HSYNC_POL when asserted
- vsync  out  1  vertical sync, level given by VSYNC_POL when asserted
- video_enable  out  1  high while the current (pixel_x, pixel_y) is in the visible area
- pixel_x  out  11  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1

Behaviour:
- One clock domain (clock). Reset is synchronous and active-high; reset is sampled only on the rising edge of clock.
- Derived constants:
  - H_TOTAL = sum of the four H parameters = 1040.
  - V_TOTAL = sum of the four V parameters = 666.
  - Frame = 692,640 clocks, about 72.19 Hz.
- pixel_x and pixel_y are the registered counters themselves.
- Every clock with reset low:
  - pixel_x increments.
  - At H_TOTAL-1 (1039), pixel_x wraps to 0 and pixel_y increments.
  - pixel_y wraps to 0 when it is V_TOTAL-1 (665) and pixel_x wraps.
- Flags are registered and computed from the next counter values. They always describe the coordinates shown in the same cycle, with zero latency relative to pixel_x/pixel_y and glitch-free outputs.
- video_enable = (pixel_x < H_VISIBLE) and (pixel_y < V_VISIBLE).
- hsync asserted when H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC, i.e. 856..975. Otherwise deasserted (the inverse of HSYNC_POL).
- vsync asserted when V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC, i.e. 637..642, for whole lines including porch pixels. Otherwise deasserted.
- Reset values:
  - pixel_x = 0, pixel_y = 0
  - video_enable = 1, since (0,0) is visible
  - hsync and vsync deasserted
- Reset mid-frame: the next edge forces the reset values regardless of the current count. Counting resumes from (0,0) on the first edge with reset low, which gives (1,0).
- Reset held high: outputs stay at their reset values.
- Counters never exceed H_TOTAL-1 or V_TOTAL-1, so no out-of-range states exist.
- Counter widths: 11 bits for x, 10 bits for y. Parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024.
- No enable input; the block runs continuously after reset.

Decomposition:
- Shared package svga_timing_pkg holds:
  - the default timing constants and the derived H_TOTAL/V_TOTAL,
  - the sync-window bounds,
  - the coordinate widths (11 and 10).
- One natural sub-module: mod_counter, a parameterised wrap-around counter with synchronous reset, count-enable and terminal-count output. It is instantiated twice; the x terminal count enables the y counter.
- Flag decode stays in the top of this block.

Test Plan:
- Reset asserted for 3 clocks, then released → pixel_x=0, pixel_y=0, video_enable=1, hsync=0, vsync=0. Next edge gives pixel_x=1.
- Run one line → video_enable is 1 for pixel_x 0..799 and 0 at 800..1039. hsync is high exactly for pixel_x 856..975 (120 clocks). After 1039, pixel_x=0 and pixel_y=1.
- Run to pixel_y 636..643 → vsync rises with pixel_y=637 at pixel_x=0 and falls with pixel_y=643 at pixel_x=0, giving 6 lines = 6240 clocks. video_enable stays 0 for all pixel_y >= 600.
- Full frame → (1039,665) is followed by (0,0). Successive pixel (0,0) occurrences are exactly 692,640 clocks apart, and vsync rising edges are exactly 692,640 clocks apart.
- Reset pulse at (500,300) for 1 clock → the next sample is (0,0) with video_enable=1, hsync=0, vsync=0. Timing then matches a fresh start.
- Parameter override H_VISIBLE=640/16/96/48 with V=480/10/2/33 and HSYNC_POL=VSYNC_POL=0 → line = 800 clocks, frame = 525 lines, hsync low only for pixel_x 656..751, vsync low only for lines 490..491.
